mem_refill_arbiter: RTL and testbench
=====================================

Name: mem_refill_arbiter

Overview:
- Shares the single word-wide main-memory port between instruction-cache refills and data-cache refills/writebacks.
- Sits between the IF-side and MEM-side caches of the RV32I core and the memory model.
- Sequences each cache-line transfer as word-serial command/response beats: optional dirty writeback first, then refill.
- Fair round-robin grant between the two requesters. Caches hold their miss stall until the done pulse.

Parameters:
LINE_WORDS, 8, words per cache line; power of two, 2..32
BEAT_W, $clog2(LINE_WORDS), beat index width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
i_req  in  1  I-cache miss request; held high until i_done
i_addr  in  32  I-side miss address; line offset ignored
i_gnt  out  1  I-side transaction in progress
i_done  out  1  one-cycle pulse: I-side line complete
d_req  in  1  D-cache miss request; held high until d_done
d_addr  in  32  D-side refill address; line offset ignored
d_wb  in  1  dirty victim must be written back first
d_wb_addr  in  32  victim line address; line offset ignored
d_wdata  in  32  victim word for index beat; driven combinationally by the D-cache
d_gnt  out  1  D-side transaction in progress
d_done  out  1  one-cycle pulse: D-side line complete
beat  out  BEAT_W  current word index within line
refill_valid  out  1  refill_data valid for word beat
refill_data  out  32  refill word
mem_cmd_valid  out  1  command valid
mem_cmd_ready  in  1  memory accepts command
mem_cmd_we  out  1  1 = write, 0 = read
mem_cmd_addr  out  32  word address
mem_cmd_wdata  out  32  write data
mem_rvalid  in  1  read data returned (one pulse per read command)
mem_rdata  in  32  read data

Behaviour:
- Reset: state IDLE; all outputs 0; beat 0; last_grant = I, so D wins the first tie.
- FSM states: IDLE, WB, RD_CMD, RD_WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One requester active: grant it at the next edge.
  - Both active: grant the requester that is not last_grant.
  - At the grant edge: latch addresses with offset bits [BEAT_W+1:0] cleared; latch d_wb; beat <= 0; assert the granted gnt.
  - Next state: WB if D is granted with d_wb = 1, else RD_CMD.
  - Latency: req high at edge N gives gnt high from cycle N+1.
- WB:
  - Drive mem_cmd_valid = 1, we = 1, addr = wb_base + (beat<<2), wdata = d_wdata.
  - On valid & ready: beat++. On beat LINE_WORDS-1: beat <= 0 and go to RD_CMD.
- RD_CMD:
  - Drive mem_cmd_valid = 1, we = 0, addr = refill_base + (beat<<2).
  - On ready: go to RD_WAIT.
- RD_WAIT:
  - mem_cmd_valid = 0.
  - On mem_rvalid: refill_valid = 1 and refill_data = mem_rdata combinationally, same cycle, with beat unchanged.
  - Then: last beat goes to DONE; otherwise beat++ and go to RD_CMD.
- DONE:
  - Pulse the granted done for one cycle with gnt still high.
  - Update last_grant to the granted requester; go to IDLE.
  - Next cycle: gnt = 0 and beat = 0.
- Command-stability rule: while mem_cmd_valid = 1 and mem_cmd_ready = 0, addr, we and wdata are held stable.
- Exactly one read command is outstanding at a time.
- mem_rvalid outside RD_WAIT is ignored.
- A request dropped mid-transaction is ignored; the transaction completes and done still pulses.
- Request address changes after grant have no effect; addresses are latched at grant.
- i_gnt and d_gnt are never both high. Neither done asserts outside DONE.
- Minimum transaction length:
  - Refill only, with zero-wait memory and rvalid one cycle after the command: 1 + 2*LINE_WORDS + 1 cycles.
  - Dirty writeback adds LINE_WORDS cycles.
- Reset mid-transaction: immediately return to IDLE with all outputs 0. Late rvalid from memory is ignored.

Decomposition:
- Shared package holds:
  - FSM state enumeration (IDLE, WB, RD_CMD, RD_WAIT, DONE).
  - Requester ID constants (REQ_I = 0, REQ_D = 1).
  - Line-offset mask function.
- One natural sub-module, rr_arbiter2: 2-way round-robin pick with last_grant register, updated on a done strobe.
- The FSM and beat counter stay in mem_refill_arbiter.

Test Plan:
- I-only miss: i_addr = 0x0000_1234, LINE_WORDS = 8, mem always ready, rvalid one cycle later.
  -> read addresses 0x1220..0x123C step 4.
  -> eight refill_valid pulses with beat 0..7.
  -> i_done once at cycle 18; d_gnt stays 0.
- D dirty miss: d_wb = 1, d_wb_addr = 0x0000_2000, d_addr = 0x0000_3000, d_wdata = 0xA000_0000 + beat.
  -> eight writes to 0x2000..0x201C carrying data 0xA0000000..0xA0000007.
  -> then eight reads from 0x3000..0x301C, then d_done.
- Simultaneous i_req and d_req straight out of reset -> D served first, then I.
- Same scenario with last_grant = D -> I served first.
- Back-to-back: both requesters re-request right after their done -> grants alternate D, I, D, I.
- Backpressure: mem_cmd_ready low for 3 cycles on beat 2 of a write -> addr 0x2008 and wdata held constant; beat stays 2.
- Reset asserted in RD_WAIT at beat 4 -> all outputs 0 immediately.
  -> A following mem_rvalid produces no refill_valid.
  -> The next i_req restarts at beat 0.

Source files
------------

// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types and helpers for the memory refill arbiter.
package mem_refill_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB      = 3'd1,
    S_RD_CMD  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Clear the line-offset bits (byte offset plus word index) of an address.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned off_bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << off_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. The last served requester loses the next tie.
module rr_arbiter2
  import mem_refill_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_upd,
  input  logic i_upd_id,
  output logic o_pick,
  output logic o_any
);

  logic r_last;

  // Remember who was served last; updated on the completion strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= REQ_I;
    end else if (i_upd) begin
      r_last <= i_upd_id;
    end
  end

  // Pick the lone requester, or the one not served last on a tie.
  always_comb begin
    o_pick = REQ_I;
    o_any  = i_req_i | i_req_d;
    if (i_req_i && i_req_d) begin
      o_pick = ~r_last;
    end else if (i_req_d) begin
      o_pick = REQ_D;
    end else begin
      o_pick = REQ_I;
    end
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares the word-wide memory port between I-cache refills and D-cache
// writeback+refill, sequencing each line as word-serial beats.
module mem_refill_arbiter
  import mem_refill_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_done,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic              d_wb,
  input  logic [31:0]       d_wb_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [BEAT_W-1:0] beat,
  output logic              refill_valid,
  output logic [31:0]       refill_data,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [31:0]       mem_cmd_addr,
  output logic [31:0]       mem_cmd_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam int unsigned       OFF_BITS  = BEAT_W + 2;

  state_t            r_state;
  logic [BEAT_W-1:0] r_beat;
  logic              r_id;
  logic              r_i_gnt;
  logic              r_d_gnt;
  logic              r_i_done;
  logic              r_d_done;
  logic [31:0]       r_rd_base;
  logic [31:0]       r_wb_base;
  logic              w_pick;
  logic              w_any;
  logic              w_upd;
  logic [31:0]       w_beat_off;

  assign w_upd      = (r_state == S_DONE);
  assign w_beat_off = {{(30 - BEAT_W){1'b0}}, r_beat, 2'b00};

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req_i  (i_req),
    .i_req_d  (d_req),
    .i_upd    (w_upd),
    .i_upd_id (r_id),
    .o_pick   (w_pick),
    .o_any    (w_any)
  );

  // Transaction sequencer: grant, optional writeback, serial refill, done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_id      <= REQ_I;
      r_i_gnt   <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_rd_base <= 32'h0;
      r_wb_base <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id      <= w_pick;
            r_i_gnt   <= (w_pick == REQ_I);
            r_d_gnt   <= (w_pick == REQ_D);
            r_beat    <= '0;
            r_wb_base <= line_base(d_wb_addr, OFF_BITS);
            r_rd_base <= (w_pick == REQ_D) ? line_base(d_addr, OFF_BITS)
                                           : line_base(i_addr, OFF_BITS);
            r_state   <= (w_pick == REQ_D && d_wb) ? S_WB : S_RD_CMD;
          end
        end
        S_WB: begin
          if (mem_cmd_ready) begin
            if (r_beat == LAST_BEAT) begin
              r_beat  <= '0;
              r_state <= S_RD_CMD;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_RD_CMD: begin
          if (mem_cmd_ready) begin
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_rvalid) begin
            if (r_beat == LAST_BEAT) begin
              r_i_done <= r_i_gnt;
              r_d_done <= r_d_gnt;
              r_state  <= S_DONE;
            end else begin
              r_beat  <= r_beat + BEAT_W'(1);
              r_state <= S_RD_CMD;
            end
          end
        end
        S_DONE: begin
          r_i_done <= 1'b0;
          r_d_done <= 1'b0;
          r_i_gnt  <= 1'b0;
          r_d_gnt  <= 1'b0;
          r_beat   <= '0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_i_done <= 1'b0;
          r_d_done <= 1'b0;
          r_i_gnt  <= 1'b0;
          r_d_gnt  <= 1'b0;
          r_beat   <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Memory command and refill forwarding decoded from the current state.
  always_comb begin
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = 32'h0;
    mem_cmd_wdata = 32'h0;
    refill_valid  = 1'b0;
    refill_data   = 32'h0;
    case (r_state)
      S_WB: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = 1'b1;
        mem_cmd_addr  = r_wb_base + w_beat_off;
        mem_cmd_wdata = d_wdata;
      end
      S_RD_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = r_rd_base + w_beat_off;
      end
      S_RD_WAIT: begin
        if (mem_rvalid) begin
          refill_valid = 1'b1;
          refill_data  = mem_rdata;
        end else begin
          refill_valid = 1'b0;
          refill_data  = 32'h0;
        end
      end
      default: begin
        mem_cmd_valid = 1'b0;
      end
    endcase
  end

  assign i_gnt  = r_i_gnt;
  assign d_gnt  = r_d_gnt;
  assign i_done = r_i_done;
  assign d_done = r_d_done;
  assign beat   = r_beat;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: memory model, command/refill
// scoreboard, and one task per scenario.
module tb_mem_refill_arbiter;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_done;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_wb;
  logic [31:0] d_wb_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [2:0]  beat;
  logic        refill_valid;
  logic [31:0] refill_data;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_we;
  logic [31:0] mem_cmd_addr;
  logic [31:0] mem_cmd_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [64:0] exp_cmd[$];   // {we, addr, wdata}
  logic [34:0] exp_rf[$];    // {beat, data}
  int          done_order[$];

  int          rv_lat = 0;
  logic        rv_pend = 1'b0;
  int          rv_wait = 0;
  logic [31:0] rv_addr = 32'h0;

  always #5 clk = ~clk;

  // D-cache victim data follows the beat index.
  assign d_wdata = 32'hA000_0000 + {29'd0, beat};

  mem_refill_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_wb(d_wb), .d_wb_addr(d_wb_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done),
    .beat(beat), .refill_valid(refill_valid), .refill_data(refill_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_wdata(mem_cmd_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: one rvalid per accepted read after rv_lat extra cycles.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (rv_pend) begin
      if (rv_wait == 0) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mdata(rv_addr);
        rv_pend    <= 1'b0;
      end else begin
        rv_wait <= rv_wait - 1;
      end
    end
    if (mem_cmd_valid && mem_cmd_ready && !mem_cmd_we) begin
      if (rv_lat == 0) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mdata(mem_cmd_addr);
      end else begin
        rv_pend <= 1'b1;
        rv_addr <= mem_cmd_addr;
        rv_wait <= rv_lat - 1;
      end
    end
  end

  // Scoreboard: compare accepted commands and refill beats in order.
  always @(negedge clk) begin
    logic [64:0] ec;
    logic [34:0] er;
    if (!rst) begin
      checks++;
      if (i_gnt && d_gnt) begin
        errors++;
        $display("FAIL gnt_exclusive: i_gnt=%b d_gnt=%b, required not both", i_gnt, d_gnt);
      end
      if (mem_cmd_valid && mem_cmd_ready) begin
        checks++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: we=%b addr=%h, required no command", mem_cmd_we, mem_cmd_addr);
        end else begin
          ec = exp_cmd.pop_front();
          if (mem_cmd_we !== ec[64] || mem_cmd_addr !== ec[63:32] ||
              (ec[64] && mem_cmd_wdata !== ec[31:0])) begin
            errors++;
            $display("FAIL cmd: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                     mem_cmd_we, mem_cmd_addr, mem_cmd_wdata, ec[64], ec[63:32], ec[31:0]);
          end
        end
      end
      if (refill_valid) begin
        checks++;
        if (exp_rf.size() == 0) begin
          errors++;
          $display("FAIL refill_unexpected: beat=%0d data=%h, required none", beat, refill_data);
        end else begin
          er = exp_rf.pop_front();
          if ({beat, refill_data} !== er) begin
            errors++;
            $display("FAIL refill: got beat=%0d data=%h, required beat=%0d data=%h",
                     beat, refill_data, er[34:32], er[31:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [31:0] base);
    for (int k = 0; k < LW; k++) begin
      exp_cmd.push_back({1'b0, base + 32'(4 * k), 32'h0});
      exp_rf.push_back({3'(k), mdata(base + 32'(4 * k))});
    end
  endtask

  task automatic push_wr(input logic [31:0] base);
    for (int k = 0; k < LW; k++) begin
      exp_cmd.push_back({1'b1, base + 32'(4 * k), 32'hA000_0000 + 32'(k)});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_wb = 1'b0;
    mem_cmd_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Collect done pulses; optionally keep requests high to re-request.
  task automatic run_dones(input int n, input bit rereq);
    int budget;
    budget = 0;
    done_order.delete();
    while (done_order.size() < n && budget < 400) begin
      tick();
      budget++;
      if (i_done) begin
        done_order.push_back(0);
        if (!rereq) i_req = 1'b0;
      end
      if (d_done) begin
        done_order.push_back(1);
        if (!rereq) d_req = 1'b0;
      end
    end
    if (budget >= 400) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d dones, required %0d", done_order.size(), n);
    end
  endtask

  task automatic test_queues_empty(input string name);
    checks++;
    if (exp_cmd.size() != 0 || exp_rf.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: cmd left %0d rf left %0d, required 0 0", name, exp_cmd.size(), exp_rf.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_wb = 1'b0;
    i_addr = 32'h0;
    d_addr = 32'h0;
    d_wb_addr = 32'h0;
    mem_cmd_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({i_gnt, i_done, d_gnt, d_done, beat, refill_valid, mem_cmd_valid, mem_cmd_we,
         mem_cmd_addr, mem_cmd_wdata, refill_data} !== 106'h0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b done=%b%b beat=%0d cmd_valid=%b, required all 0",
               i_gnt, d_gnt, i_done, d_done, beat, mem_cmd_valid);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({i_gnt, d_gnt, mem_cmd_valid, beat} !== 6'h0) begin
      errors++;
      $display("FAIL idle_outputs: gnt=%b%b cmd_valid=%b beat=%0d, required 0",
               i_gnt, d_gnt, mem_cmd_valid, beat);
    end
  endtask

  task automatic test_i_only();
    int done_at;
    int dcount;
    bit dgnt_seen;
    done_at = 0;
    dcount = 0;
    dgnt_seen = 1'b0;
    push_rd(32'h0000_1220);
    i_addr = 32'h0000_1234;
    i_req = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      tick();
      if (cyc == 1) begin
        checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
          errors++;
          $display("FAIL i_grant_latency: i_gnt=%b d_gnt=%b, required 1 0", i_gnt, d_gnt);
        end
        i_addr = 32'hDEAD_0000;
      end
      if (d_gnt) dgnt_seen = 1'b1;
      if (i_done) begin
        dcount++;
        if (done_at == 0) done_at = cyc;
        i_req = 1'b0;
      end
    end
    checks++;
    if (done_at != 17 || dcount != 1) begin
      errors++;
      $display("FAIL i_done_timing: edge %0d count %0d, required edge 17 count 1", done_at, dcount);
    end
    checks++;
    if (dgnt_seen) begin
      errors++;
      $display("FAIL i_only_dgnt: d_gnt=1 seen, required 0");
    end
    test_queues_empty("i_only");
  endtask

  task automatic test_d_dirty(input bit stall);
    int done_at;
    done_at = 0;
    push_wr(32'h0000_2000);
    push_rd(32'h0000_3000);
    d_wb = 1'b1;
    d_wb_addr = 32'h0000_2000;
    d_addr = 32'h0000_301C;
    d_req = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (cyc == 1) begin
        d_addr = 32'h0BAD_0000;
        d_wb_addr = 32'h0BAD_1000;
      end
      mem_cmd_ready = !(stall && cyc >= 3 && cyc <= 5);
      if (stall && cyc >= 3 && cyc <= 5) begin
        checks++;
        if (beat !== 3'd2 || mem_cmd_addr !== 32'h0000_2008 || mem_cmd_wdata !== 32'hA000_0002 ||
            mem_cmd_we !== 1'b1 || mem_cmd_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold cyc %0d: beat=%0d addr=%h wdata=%h we=%b valid=%b, required 2 00002008 a0000002 1 1",
                   cyc, beat, mem_cmd_addr, mem_cmd_wdata, mem_cmd_we, mem_cmd_valid);
        end
      end
      if (d_done && done_at == 0) begin
        done_at = cyc;
        d_req = 1'b0;
      end
    end
    mem_cmd_ready = 1'b1;
    d_wb = 1'b0;
    checks++;
    if (done_at != (stall ? 28 : 25)) begin
      errors++;
      $display("FAIL d_done_timing: edge %0d, required %0d", done_at, stall ? 28 : 25);
    end
    test_queues_empty(stall ? "backpressure" : "d_dirty");
  endtask

  task automatic test_tie(input bit expect_i_first);
    if (expect_i_first) begin
      push_rd(32'h0000_4000);
      push_rd(32'h0000_5000);
    end else begin
      push_rd(32'h0000_5000);
      push_rd(32'h0000_4000);
    end
    i_addr = 32'h0000_4000;
    d_addr = 32'h0000_5000;
    d_wb = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    run_dones(2, 1'b0);
    checks++;
    if (done_order.size() != 2 || done_order[0] != (expect_i_first ? 0 : 1) ||
        done_order[1] != (expect_i_first ? 1 : 0)) begin
      errors++;
      $display("FAIL tie_order: got %p, required first=%s", done_order, expect_i_first ? "I" : "D");
    end
    test_queues_empty("tie");
  endtask

  task automatic test_d_only_then_tie();
    push_rd(32'h0000_5000);
    d_addr = 32'h0000_5000;
    d_wb = 1'b0;
    d_req = 1'b1;
    run_dones(1, 1'b0);
    test_tie(1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      push_rd(32'h0000_5000);
      push_rd(32'h0000_4000);
    end
    i_addr = 32'h0000_4000;
    d_addr = 32'h0000_5000;
    i_req = 1'b1;
    d_req = 1'b1;
    run_dones(4, 1'b1);
    i_req = 1'b0;
    d_req = 1'b0;
    checks++;
    if (done_order.size() != 4 || done_order[0] != 1 || done_order[1] != 0 ||
        done_order[2] != 1 || done_order[3] != 0) begin
      errors++;
      $display("FAIL back_to_back_order: got %p, required D I D I", done_order);
    end
    tick();
    tick();
    test_queues_empty("back_to_back");
  endtask

  task automatic test_reset_mid();
    int budget;
    int rv_seen;
    budget = 0;
    rv_seen = 0;
    rv_lat = 6;
    push_rd(32'h0000_8000);
    i_addr = 32'h0000_8000;
    i_req = 1'b1;
    while (!(i_gnt && beat == 3'd4 && !mem_cmd_valid) && budget < 200) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 200) begin
      errors++;
      $display("FAIL reach_rd_wait_beat4: timed out, required RD_WAIT beat 4");
    end
    rst = 1'b1;
    i_req = 1'b0;
    #1;
    checks++;
    if ({i_gnt, i_done, d_gnt, d_done, beat, refill_valid, mem_cmd_valid, mem_cmd_we,
         mem_cmd_addr, mem_cmd_wdata, refill_data} !== 106'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: gnt=%b%b beat=%0d cmd_valid=%b addr=%h, required all 0",
               i_gnt, d_gnt, beat, mem_cmd_valid, mem_cmd_addr);
    end
    checks++;
    if (exp_cmd.size() != 3 || exp_rf.size() != 4) begin
      errors++;
      $display("FAIL reset_mid_progress: cmd left %0d rf left %0d, required 3 4", exp_cmd.size(), exp_rf.size());
    end
    exp_cmd.delete();
    exp_rf.delete();
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (mem_rvalid) rv_seen++;
      checks++;
      if (refill_valid !== 1'b0) begin
        errors++;
        $display("FAIL late_rvalid: refill_valid=%b, required 0", refill_valid);
      end
    end
    checks++;
    if (rv_seen != 1) begin
      errors++;
      $display("FAIL late_rvalid_seen: %0d, required 1", rv_seen);
    end
    rv_lat = 0;
    push_rd(32'h0000_9000);
    i_addr = 32'h0000_9000;
    i_req = 1'b1;
    tick();
    checks++;
    if (i_gnt !== 1'b1 || beat !== 3'd0 || mem_cmd_addr !== 32'h0000_9000) begin
      errors++;
      $display("FAIL restart: i_gnt=%b beat=%0d addr=%h, required 1 0 00009000", i_gnt, beat, mem_cmd_addr);
    end
    run_dones(1, 1'b0);
    test_queues_empty("reset_mid");
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_d_dirty(1'b0);
    test_d_dirty(1'b1);
    do_reset();
    test_tie(1'b0);
    test_d_only_then_tie();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
